// File: rtl/crossing_pkg.sv
// Shared phase encodings and grant identifiers for the pedestrian crossing scheduler.
// Phase values appear directly on the phase output, so the encoding is part of the interface.
package crossing_pkg;

  typedef enum logic [2:0] {
    ST_ROAD_GREEN      = 3'd0,
    ST_ROAD_YELLOW     = 3'd1,
    ST_ALL_RED_IN      = 3'd2,
    ST_PED_GREEN       = 3'd3,
    ST_PED_BLINK       = 3'd4,
    ST_ALL_RED_OUT     = 3'd5,
    ST_ROAD_RED_YELLOW = 3'd6
  } state_e;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // Road lamp triple {red, yellow, green} for a given phase.
  function automatic logic [2:0] road_lamps(input state_e s);
    logic [2:0] l;
    case (s)
      ST_ROAD_GREEN:      l = 3'b001;
      ST_ROAD_YELLOW:     l = 3'b010;
      ST_ROAD_RED_YELLOW: l = 3'b110;
      default:            l = 3'b100;
    endcase
    return l;
  endfunction

  function automatic logic is_ped_phase(input state_e s);
    return (s == ST_PED_GREEN) || (s == ST_PED_BLINK);
  endfunction

endpackage

// File: rtl/crossing_scheduler_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, first tick TICK_DIV cycles after reset.
// No backpressure; tick is a pure function of the counter.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/crossing_scheduler.sv
// Road / two-crossing lamp scheduler; phases advance on prescaled ticks, outputs are registered-state decodes.
// Optional flashing pedestrian phase when CROSSING_PED_BLINK_EN is defined.
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter logic [7:0]  T_MIN_GREEN  = 8'd5,
  parameter logic [7:0]  T_YELLOW     = 8'd1,
  parameter logic [7:0]  T_ALL_RED    = 8'd2,
  parameter logic [7:0]  T_PED_GREEN  = 8'd4,
  parameter logic [7:0]  T_PED_BLINK  = 8'd2,
  parameter logic [7:0]  T_RED_YELLOW = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  output logic       road_red,
  output logic       road_yellow,
  output logic       road_green,
  output logic       ped_a_red,
  output logic       ped_a_green,
  output logic       ped_b_red,
  output logic       ped_b_green,
  output logic       pend_a,
  output logic       pend_b,
  output logic [2:0] phase
);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pend_a_q, pend_a_d;
  logic       pend_b_q, pend_b_d;
  logic       ptr_q, ptr_d;
  logic       grant_q, grant_d;
  logic       second_q, second_d;
  logic       tick;
  logic       expire;
  logic       pick;
  logic       other_pend;
  logic       enter_pg;
  logic       serving_a, serving_b;
  logic       ped_lit;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  function automatic logic [7:0] phase_dur(input state_e s);
    logic [7:0] d;
    case (s)
      ST_ROAD_GREEN:      d = T_MIN_GREEN;
      ST_ROAD_YELLOW:     d = T_YELLOW;
      ST_ALL_RED_IN:      d = T_ALL_RED;
      ST_PED_GREEN:       d = T_PED_GREEN;
      ST_PED_BLINK:       d = T_PED_BLINK;
      ST_ALL_RED_OUT:     d = T_ALL_RED;
      ST_ROAD_RED_YELLOW: d = T_RED_YELLOW;
      default:            d = T_MIN_GREEN;
    endcase
    return d;
  endfunction

  assign expire = tick && (timer_q == 8'd0);

  // Tie-break only matters when both are pending; the pointer names the crossing not served last.
  assign pick = (pend_a_q && !pend_b_q) ? GRANT_A :
                (pend_b_q && !pend_a_q) ? GRANT_B : ptr_q;

  assign other_pend = (grant_q == GRANT_A) ? pend_b_q : pend_a_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_ROAD_GREEN: begin
        if (expire && (pend_a_q || pend_b_q)) state_d = ST_ROAD_YELLOW;
      end
      ST_ROAD_YELLOW: begin
        if (expire) state_d = ST_ALL_RED_IN;
      end
      ST_ALL_RED_IN: begin
        if (expire) begin
          state_d = ST_PED_GREEN;
          grant_d = pick;
        end
      end
      ST_PED_GREEN: begin
`ifdef CROSSING_PED_BLINK_EN
        if (expire) state_d = ST_PED_BLINK;
`else
        if (expire) state_d = ST_ALL_RED_OUT;
`endif
      end
      ST_PED_BLINK: begin
        if (expire) state_d = ST_ALL_RED_OUT;
      end
      ST_ALL_RED_OUT: begin
        if (expire) begin
          if (!second_q && other_pend) begin
            state_d = ST_PED_GREEN;
            grant_d = ~grant_q;
          end else begin
            state_d = ST_ROAD_RED_YELLOW;
          end
        end
      end
      ST_ROAD_RED_YELLOW: begin
        if (expire) state_d = ST_ROAD_GREEN;
      end
      default: state_d = ST_ROAD_GREEN;
    endcase
  end

  assign enter_pg  = (state_d == ST_PED_GREEN) && (state_q != ST_PED_GREEN);
  assign serving_a = is_ped_phase(state_q) && (grant_q == GRANT_A);
  assign serving_b = is_ped_phase(state_q) && (grant_q == GRANT_B);

  // Phase timer, request latches and sequence bookkeeping
  always_comb begin
    timer_d  = timer_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    ptr_d    = ptr_q;
    second_d = second_q;

    if (state_d != state_q) begin
      timer_d = phase_dur(state_d) - 8'd1;
    end else if (tick && (timer_q != 8'd0)) begin
      timer_d = timer_q - 8'd1;
    end

    // A press in the cycle of entry counts as served, hence the clear wins.
    if (enter_pg && (grant_d == GRANT_A)) begin
      pend_a_d = 1'b0;
    end else if (ped_req_a && !serving_a) begin
      pend_a_d = 1'b1;
    end

    if (enter_pg && (grant_d == GRANT_B)) begin
      pend_b_d = 1'b0;
    end else if (ped_req_b && !serving_b) begin
      pend_b_d = 1'b1;
    end

    if (enter_pg) begin
      ptr_d    = ~grant_d;
      second_d = (state_q == ST_ALL_RED_OUT);
    end
  end

`ifdef CROSSING_PED_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if ((state_d == ST_PED_BLINK) && (state_q != ST_PED_BLINK)) begin
      blink_d = 1'b1;
    end else if ((state_q == ST_PED_BLINK) && tick) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign ped_lit = (state_q == ST_PED_GREEN) || ((state_q == ST_PED_BLINK) && blink_q);
`else
  assign ped_lit = (state_q == ST_PED_GREEN);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ROAD_GREEN;
      timer_q  <= T_MIN_GREEN - 8'd1;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      ptr_q    <= GRANT_A;
      grant_q  <= GRANT_A;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      second_q <= second_d;
    end
  end

  // Output decode; lamps depend on registered state only, so reset reaches them immediately.
  always_comb begin
    {road_red, road_yellow, road_green} = road_lamps(state_q);
    ped_a_green = ped_lit && (grant_q == GRANT_A);
    ped_b_green = ped_lit && (grant_q == GRANT_B);
    ped_a_red   = ~ped_a_green;
    ped_b_red   = ~ped_b_green;
    pend_a      = pend_a_q;
    pend_b      = pend_b_q;
    phase       = state_q;
  end

endmodule
